mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory (1024 x D_SIZE words) between two requesters: the pipeline's instruction-fetch stage and its load/store (data memory) stage.
- Serialises one transaction at a time through a fixed-latency memory.
- Returns a one-cycle ack with read data to the winning requester.
- Data accesses have priority by default; a starvation limit guarantees fetch progress.

Parameters:
- D_SIZE, 32, memory word width in bits.
- AW, 10, word-address width (1024 words).
- MEM_LAT, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15.
- STARVE_LIM, 4, consecutive data grants with fetch pending, after which fetch wins; legal range 1..15.

Ports:
- clk, input, 1, single system clock; all logic on posedge.
- reset, input, 1, synchronous, active-high.
- if_req, input, 1, fetch request; held high with if_addr stable until if_ack.
- if_addr, input, AW, fetch word address.
- if_ack, output, 1, one-cycle pulse; fetch transaction complete.
- if_rdata, output, D_SIZE, fetch read data; valid only while if_ack=1.
- dm_req, input, 1, data request; held high with dm_we, dm_addr and dm_wdata stable until dm_ack.
- dm_we, input, 1, 1 = store, 0 = load.
- dm_addr, input, AW, data word address.
- dm_wdata, input, D_SIZE, store data.
- dm_ack, output, 1, one-cycle pulse; data transaction complete.
- dm_rdata, output, D_SIZE, load data; valid only while dm_ack=1 and the access was a load.
- mem_en, output, 1, one-cycle strobe issuing a memory access.
- mem_we, output, 1, write enable accompanying mem_en.
- mem_addr, output, AW, memory word address.
- mem_wdata, output, D_SIZE, memory write data.
- mem_rdata, input, D_SIZE, memory read data; valid MEM_LAT cycles after mem_en.
- busy, output, 1, high in any state other than IDLE.
- conflict_cnt, output, 16, saturating count of arbitration decisions where both requests were high.

Behaviour:
- Reset values: state=IDLE. if_ack, dm_ack, mem_en, mem_we and busy are 0. mem_addr, mem_wdata and conflict_cnt are 0. Starvation counter is 0. owner=FETCH.
- States and transitions:
  - IDLE: samples requests. If any request is high, go to ISSUE.
  - ISSUE: 1 cycle. mem_en=1. Then go to WAIT if MEM_LAT>1, else go to RESP.
  - WAIT: MEM_LAT-1 cycles, counted with a 4-bit down-counter. Then go to RESP.
  - RESP: 1 cycle. Assert the ack of the owner. Then go to IDLE.
- Arbitration happens in IDLE on the edge that leaves IDLE:
  - Only one request high: that requester wins.
  - Both requests high: dm wins, unless starve_cnt == STARVE_LIM, in which case if wins.
  - The winner is latched as owner. Its address, we and wdata are latched into mem_addr, mem_we and mem_wdata. For fetch, mem_we=0.
  - mem_addr, mem_we and mem_wdata stay stable from ISSUE through RESP and hold their value in IDLE. mem_we is only meaningful while mem_en=1.
- Latency: request seen in IDLE at cycle t → mem_en at t+1 → ack at t+1+MEM_LAT. Throughput is one transaction per MEM_LAT+2 cycles when requests are continuous.
- Ack and read data:
  - if_rdata and dm_rdata are driven from mem_rdata in RESP.
  - Outside its ack, each rdata output is 0.
  - A store acks the same way; its dm_rdata is don't-care.
- Request handling after ack:
  - A requester sampling its ack may keep req high for its next transaction. A req high in the IDLE cycle after RESP is a new request.
  - The arbiter ignores req changes outside IDLE.
  - A req dropped before its ack is a protocol violation and has undefined result.
- Starvation counter (3-bit minimum, saturating at STARVE_LIM):
  - Increments on a dm grant while if_req=1.
  - Clears on any if grant.
  - Clears in IDLE when if_req=0.
- conflict_cnt increments by 1 on each IDLE decision with if_req & dm_req, and saturates at 16'hFFFF.
- Reset mid-operation (any state): go to IDLE next cycle. The in-flight access is abandoned; no ack is issued, and a later mem_rdata is ignored. Counters are cleared.
- No combinational path from req inputs to any output. Acks are registered state decodes; rdata passes through from mem_rdata.

Test Plan:
- MEM_LAT=2, only if_req=1 with if_addr=10'd5 at cycle 0 (IDLE) → mem_en=1, mem_we=0, mem_addr=5 at cycle 1. if_ack=1 with if_rdata = memory word 5 at cycle 3. busy is high in cycles 1-3.
- Store then load: dm_we=1, dm_addr=350, dm_wdata=32'd1234 → dm_ack at t+3. Then load with dm_addr=350 → dm_rdata=1234 on dm_ack.
- if_req and dm_req both high in IDLE → dm served first, if served in the next transaction. conflict_cnt=1.
- STARVE_LIM=4, both requests held continuously, each re-requested on ack → grant order dm,dm,dm,dm,if,dm,dm,dm,dm,if. No fetch waits more than 4 data transactions.
- MEM_LAT=1 → ack at t+2, and back-to-back fetches produce mem_en every 3 cycles.
- reset=1 during WAIT with dm load outstanding → next cycle IDLE, no dm_ack ever for that load. conflict_cnt=0. A fresh if_req after reset deassertion is served with normal latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported, fixed-latency memory between instruction fetch
// and load/store. Data wins by default; a starvation limit forces fetch progress.
module mem_port_arbiter #(
    parameter int D_SIZE     = 32,
    parameter int AW         = 10,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_ack,
    output logic [D_SIZE-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [AW-1:0]     dm_addr,
    input  logic [D_SIZE-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [D_SIZE-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [D_SIZE-1:0] mem_wdata,
    input  logic [D_SIZE-1:0] mem_rdata,
    output logic              busy,
    output logic [15:0]       conflict_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic       OWN_FETCH  = 1'b0;
    localparam logic       OWN_DATA   = 1'b1;
    localparam logic       LAT_GT1    = (MEM_LAT > 1);
    localparam logic [3:0] LAT_M1     = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

    logic [1:0]        r_state;
    logic [3:0]        r_wait_cnt;
    logic              r_owner;
    logic [3:0]        r_starve_cnt;
    logic [15:0]       r_conflict_cnt;
    logic              r_if_ack;
    logic              r_dm_ack;
    logic              r_mem_en;
    logic              r_mem_we;
    logic              r_busy;
    logic [AW-1:0]     r_mem_addr;
    logic [D_SIZE-1:0] r_mem_wdata;

    logic              w_any_req;
    logic              w_both_req;
    logic              w_pick_if;
    logic              w_grant;
    logic [1:0]        w_state_nxt;

    // Arbitration decision, evaluated against the requests seen in IDLE
    always_comb begin
        w_any_req  = if_req | dm_req;
        w_both_req = if_req & dm_req;
        w_pick_if  = if_req & (~dm_req | (r_starve_cnt == STARVE_MAX));
        w_grant    = (r_state == S_IDLE) & w_any_req;
    end

    // Next-state logic for the transaction sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (LAT_GT1) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            S_WAIT: begin
                if (r_wait_cnt == 4'd1) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sequencer state, latched transaction and registered strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 4'd0;
            r_owner     <= OWN_FETCH;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_en    <= 1'b0;
            r_if_ack    <= 1'b0;
            r_dm_ack    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mem_en <= (w_state_nxt == S_ISSUE);
            r_busy   <= (w_state_nxt != S_IDLE);
            // Owner is already stable whenever RESP is entered
            r_if_ack <= (w_state_nxt == S_RESP) & (r_owner == OWN_FETCH);
            r_dm_ack <= (w_state_nxt == S_RESP) & (r_owner == OWN_DATA);
            if (r_state == S_ISSUE) begin
                r_wait_cnt <= LAT_M1;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end
            if (w_grant) begin
                r_owner     <= w_pick_if ? OWN_FETCH : OWN_DATA;
                r_mem_addr  <= w_pick_if ? if_addr : dm_addr;
                r_mem_we    <= w_pick_if ? 1'b0 : dm_we;
                r_mem_wdata <= w_pick_if ? '0 : dm_wdata;
            end else begin
                r_owner     <= r_owner;
                r_mem_addr  <= r_mem_addr;
                r_mem_we    <= r_mem_we;
                r_mem_wdata <= r_mem_wdata;
            end
        end
    end

    // Starvation and conflict counters, both updated only on IDLE decisions
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt   <= 4'd0;
            r_conflict_cnt <= 16'd0;
        end else begin
            if (r_state != S_IDLE) begin
                r_starve_cnt <= r_starve_cnt;
            end else if (!if_req || w_pick_if) begin
                r_starve_cnt <= 4'd0;
            end else if (dm_req && (r_starve_cnt != STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end else begin
                r_starve_cnt <= r_starve_cnt;
            end
            if ((r_state == S_IDLE) && w_both_req && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end else begin
                r_conflict_cnt <= r_conflict_cnt;
            end
        end
    end

    assign if_ack       = r_if_ack;
    assign dm_ack       = r_dm_ack;
    assign if_rdata     = r_if_ack ? mem_rdata : '0;
    assign dm_rdata     = r_dm_ack ? mem_rdata : '0;
    assign mem_en       = r_mem_en;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign busy         = r_busy;
    assign conflict_cnt = r_conflict_cnt;

endmodule
